// File: rtl/pmod_pwm_pkg.sv
// rtl/pmod_pwm_pkg.sv - shared constants, FSM state type and saturation helper for the Pmod PWM receiver
//
// Contents:
//   SAMPLE_W    width of the recovered two's-complement sample
//   SAMPLE_MAX  largest representable sample (+2047)
//   SAMPLE_MIN  smallest representable sample (-2048)
//   state_t     window FSM states (IDLE, COUNT)
//   sat_sample  clamps a SAMPLE_W+1 bit signed value into SAMPLE_W bits
package pmod_pwm_pkg;

    localparam int SAMPLE_W = 12;

    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 12'sh7FF;
    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 12'sh800;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Only a fully-high window (+2048 after scaling) exceeds the range, but
    // both limits are handled so the helper stays correct for any input.
    function automatic logic signed [SAMPLE_W-1:0] sat_sample(
        input logic signed [SAMPLE_W:0] v
    );
        if (v > $signed({1'b0, SAMPLE_MAX})) begin
            return SAMPLE_MAX;
        end else if (v < $signed({1'b1, SAMPLE_MIN})) begin
            return SAMPLE_MIN;
        end else begin
            return $signed(v[SAMPLE_W-1:0]);
        end
    endfunction

endpackage

// File: rtl/pmod_pwm_rx_sync.sv
// rtl/pmod_pwm_rx_sync.sv - pin synchronizer, optional majority deglitch and edge detectors
//
// Optional feature macro: PMOD_PWM_RX_DEGLITCH_EN
//   defined   : a 3-tap majority filter follows the synchronizer (+2 cycles latency)
//   undefined : pin_s is the raw synchronizer output
//
// Ports:
//   clk       in   clock, all state on rising edge
//   rst       in   asynchronous active-high reset
//   pwm_in    in   asynchronous PWM line from the Pmod pin
//   pin_s     out  conditioned, synchronous copy of pwm_in
//   rise      out  pin_s rising edge (pin_s & ~previous pin_s)
//   any_edge  out  pin_s changed since the previous cycle
module pmod_pwm_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic pin_s,
    output logic rise,
    output logic any_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   pin_s_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PMOD_PWM_RX_DEGLITCH_EN
    // Majority of the current and two previous synchronized samples, then
    // registered: a level must persist two cycles before it reaches pin_s.
    logic [1:0] tap_q;
    logic       maj;
    logic       maj_q;

    assign maj = (sync_out & tap_q[0]) | (sync_out & tap_q[1]) | (tap_q[0] & tap_q[1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_q <= '0;
            maj_q <= 1'b0;
        end else begin
            tap_q <= {tap_q[0], sync_out};
            maj_q <= maj;
        end
    end

    assign pin_s = maj_q;
`else
    assign pin_s = sync_out;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pin_s_d <= 1'b0;
        end else begin
            pin_s_d <= pin_s;
        end
    end

    assign rise     = pin_s & ~pin_s_d;
    assign any_edge = pin_s ^ pin_s_d;

endmodule

// File: rtl/pmod_pwm_rx.sv
// rtl/pmod_pwm_rx.sv - PWM / pulse-density receiver recovering a signed 12-bit sample per window
//
// Optional feature macro: PMOD_PWM_RX_DEGLITCH_EN (majority deglitch inside pmod_pwm_rx_sync)
//
// Parameters:
//   WIN_LOG2     window length is 2^WIN_LOG2 clk cycles (legal 4..12)
//   SYNC_STAGES  synchronizer depth (minimum 2)
//
// Ports:
//   clk           in   clock, all state on rising edge
//   rst           in   asynchronous active-high reset
//   pwm_in        in   asynchronous PWM line from the Pmod pin
//   sample_out    out  most recent recovered sample (signed 12)
//   sample_valid  out  sample_out holds an unconsumed sample
//   sample_ready  in   downstream accepts when sample_valid is also high
//   overrun       out  one-cycle pulse when an unconsumed sample is overwritten
//   active        out  an edge of the conditioned input occurred in the last completed window
module pmod_pwm_rx
    import pmod_pwm_pkg::*;
#(
    parameter int WIN_LOG2    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pwm_in,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_valid,
    input  logic                       sample_ready,
    output logic                       overrun,
    output logic                       active
);

    localparam int                  WIN   = 1 << WIN_LOG2;
    localparam int                  SHIFT = SAMPLE_W - WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] LAST  = '1;

    logic pin_s;
    logic rise;
    logic any_edge;

    pmod_pwm_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .pwm_in  (pwm_in),
        .pin_s   (pin_s),
        .rise    (rise),
        .any_edge(any_edge)
    );

    state_t state_q;
    state_t state_d;
    logic   win_done;
    logic   enter_count;

    logic [WIN_LOG2-1:0] win_cnt;
    logic [WIN_LOG2-1:0] idle_cnt;
    logic [WIN_LOG2:0]   high_cnt;
    logic                edge_seen;

    logic [WIN_LOG2:0]          high_final;
    logic [SAMPLE_W:0]          d_raw;
    logic signed [SAMPLE_W:0]   d_scaled;
    logic signed [SAMPLE_W-1:0] sample_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        win_done    = 1'b0;
        enter_count = 1'b0;
        case (state_q)
            IDLE: begin
                // Start on the first rising edge, or free-run after a full
                // silent window so a stuck line still yields samples.
                if (rise || (idle_cnt == LAST)) begin
                    state_d     = COUNT;
                    enter_count = 1'b1;
                end
            end
            COUNT: begin
                if (win_cnt == LAST) begin
                    win_done = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The last cycle of a window contributes its own pin_s to the total.
    assign high_final = high_cnt + (WIN_LOG2 + 1)'(pin_s);

    // Centre the count on zero in modular SAMPLE_W+1 bit arithmetic, then
    // scale to full 12-bit range; only a fully-high window needs clamping.
    assign d_raw       = (SAMPLE_W + 1)'(high_final) - (SAMPLE_W + 1)'(WIN / 2);
    assign d_scaled    = $signed(d_raw) <<< SHIFT;
    assign sample_next = sat_sample(d_scaled);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt   <= '0;
            idle_cnt  <= '0;
            high_cnt  <= '0;
            edge_seen <= 1'b0;
        end else if (state_q == IDLE) begin
            // Counters are held at zero here, so entering COUNT starts a
            // fresh window; a partial window never reaches the output.
            win_cnt   <= '0;
            high_cnt  <= '0;
            edge_seen <= 1'b0;
            idle_cnt  <= enter_count ? '0 : idle_cnt + WIN_LOG2'(1);
        end else if (win_done) begin
            win_cnt   <= '0;
            high_cnt  <= '0;
            edge_seen <= 1'b0;
        end else begin
            win_cnt   <= win_cnt + WIN_LOG2'(1);
            high_cnt  <= high_final;
            edge_seen <= edge_seen | any_edge;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            active       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (win_done) begin
                sample_out   <= sample_next;
                sample_valid <= 1'b1;
                active       <= edge_seen | any_edge;
                // A same-cycle transfer frees the slot, so no loss occurs.
                overrun      <= sample_valid & ~sample_ready;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pmod_pwm_rx.sv
// tb/tb_pmod_pwm_rx.sv - directed self-checking bench for pmod_pwm_rx (WIN_LOG2 = 8)
module tb_pmod_pwm_rx;

    logic               clk;
    logic               rst;
    logic               pwm_in;
    logic signed [11:0] sample_out;
    logic               sample_valid;
    logic               sample_ready;
    logic               overrun;
    logic               active;

    int    n_vec;
    int    n_bad;
    logic  level;
    logic  sq_en;
    int    high_len;
    int    ph;

    pmod_pwm_rx #(
        .WIN_LOG2   (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .overrun     (overrun),
        .active      (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pin driver: constant level, or a period-16 square wave with
    // high_len high cycles; updated shortly after each rising edge.
    initial begin
        pwm_in = 1'b0;
        ph     = 0;
        forever begin
            @(posedge clk);
            #2;
            pwm_in = sq_en ? (ph < high_len) : level;
            ph     = (ph + 1) % 16;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_valid && n < bound);
        check_eq({tag, "_valid"}, int'(sample_valid), 1);
    endtask

    int n;
    int ovr;
    int duty_len [3] = '{8, 4, 12};
    int duty_exp [3] = '{0, -1024, 1024};
    int exp_dg;
    int exp_dg_act;

    initial begin
        n_vec        = 0;
        n_bad        = 0;
        rst          = 1'b1;
        sample_ready = 1'b1;
        level        = 1'b0;
        sq_en        = 1'b0;
        high_len     = 8;

        repeat (3) @(negedge clk);
        check_eq("rst_sample", int'(sample_out), 0);
        check_eq("rst_valid", int'(sample_valid), 0);
        check_eq("rst_overrun", int'(overrun), 0);
        check_eq("rst_active", int'(active), 0);
        rst = 1'b0;

        // Constant low: idle timeout then one -2048 sample per window.
        wait_valid("low_first", 1000, n);
        check_eq("low_sample", int'(sample_out), -2048);
        check_eq("low_active", int'(active), 0);
        @(negedge clk);
        check_eq("low_valid_drop", int'(sample_valid), 0);
        wait_valid("low_next", 300, n);
        check_eq("low_period", n, 255);
        check_eq("low_sample2", int'(sample_out), -2048);

        // Constant high: saturates to +2047, no edges inside the window.
        level = 1'b1;
        wait_valid("high_mix", 300, n);
        wait_valid("high_full", 300, n);
        check_eq("high_sample", int'(sample_out), 2047);
        check_eq("high_active", int'(active), 0);

        // Square waves of period 16.
        sq_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            high_len = duty_len[i];
            wait_valid("duty_mix", 300, n);
            wait_valid("duty_full", 300, n);
            check_eq($sformatf("duty%0d_sample", duty_len[i]), int'(sample_out), duty_exp[i]);
            check_eq($sformatf("duty%0d_active", duty_len[i]), int'(active), 1);
        end

        // Backpressure for three 25% windows.
        high_len = 4;
        wait_valid("bp_mix", 300, n);
        @(negedge clk);
        sample_ready = 1'b0;
        ovr = 0;
        repeat (768) begin
            @(negedge clk);
            if (overrun) ovr++;
        end
        check_eq("bp_overrun_cnt", ovr, 2);
        check_eq("bp_sample", int'(sample_out), -1024);
        check_eq("bp_valid_held", int'(sample_valid), 1);
        sample_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_valid_after_xfer", int'(sample_valid), 0);
        wait_valid("bp_next", 300, n);
        check_eq("bp_gap", n, 254);

        // Coincident accept: ready rises on the completion cycle.
        sample_ready = 1'b0;
        high_len     = 12;
        for (int i = 1; i <= 511; i++) begin
            @(negedge clk);
            if (i == 256) check_eq("co_prev_overrun", int'(overrun), 1);
            if (i == 511) sample_ready = 1'b1;
        end
        @(negedge clk);
        check_eq("co_overrun", int'(overrun), 0);
        check_eq("co_valid", int'(sample_valid), 1);
        check_eq("co_sample", int'(sample_out), 1024);
        @(negedge clk);
        check_eq("co_valid_drop", int'(sample_valid), 0);

        // Reset at win_cnt = 100.
        wait_valid("mid_align", 300, n);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_sample", int'(sample_out), 0);
        check_eq("mid_rst_valid", int'(sample_valid), 0);
        check_eq("mid_rst_overrun", int'(overrun), 0);
        check_eq("mid_rst_active", int'(active), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_valid("mid_first", 400, n);
        check_eq("mid_first_latency_ok", int'(n >= 256 && n <= 290), 1);
        check_eq("mid_first_sample", int'(sample_out), 1024);

        // Single-cycle pulse on a low line.
`ifdef PMOD_PWM_RX_DEGLITCH_EN
        exp_dg     = -2048;
        exp_dg_act = 0;
`else
        exp_dg     = -2032;
        exp_dg_act = 1;
`endif
        sq_en = 1'b0;
        level = 1'b0;
        wait_valid("dg_mix", 300, n);
        repeat (50) @(negedge clk);
        level = 1'b1;
        @(negedge clk);
        level = 1'b0;
        wait_valid("dg_full", 300, n);
        check_eq("dg_sample", int'(sample_out), exp_dg);
        check_eq("dg_active", int'(active), exp_dg_act);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pmod_pwm_rx.md
# pmod_pwm_rx

Receive-side counterpart of the Pmod PWM output path: it samples a 1-bit PWM / pulse-density line from a Pmod pin and recovers a signed 12-bit sample stream. It synchronizes the asynchronous pin and measures duty cycle over a fixed power-of-two window. Each completed window produces one two's-complement sample, delivered downstream over a valid/ready handshake. It sits between the Pmod input pin and the sample-processing datapath (CORDIC/filter input).

## Interface
- `WIN_LOG2`, default 8: window length is 2^WIN_LOG2 clk cycles. Legal range 4..12.
- `SYNC_STAGES`, default 2: synchronizer depth. Minimum 2.
- `clk` in, 1: single clock; all state is on its rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `pwm_in` in, 1: asynchronous PWM line from the Pmod pin.
- `sample_out` out, signed 12: most recent recovered sample.
- `sample_valid` out, 1: `sample_out` holds an unconsumed sample.
- `sample_ready` in, 1: downstream accepts the sample when `sample_valid` is also high.
- `overrun` out, 1: one-cycle pulse when an unconsumed sample is overwritten.
- `active` out, 1: at least one edge of the synchronized input occurred in the last completed window.

## Operation
- **Input conditioning:** `pwm_in` passes through a `SYNC_STAGES` flop chain, giving `pin_s`. The rising-edge detect is `pin_s & ~pin_s_d`.
- **FSM states:**
  - IDLE, entered on reset.
    - Leaves for COUNT on the first rising edge of `pin_s`.
    - Also leaves for COUNT after 2^WIN_LOG2 cycles with no edge (idle timeout).
    - On entry to COUNT, `win_cnt` and `high_cnt` are cleared.
  - COUNT:
    - Each cycle, `win_cnt` increments and `high_cnt` increments when `pin_s` is 1.
    - When `win_cnt == 2^WIN_LOG2-1`, the final `high_cnt` is that cycle's value including the current `pin_s`.
    - On that cycle, both counters wrap to 0 and the FSM stays in COUNT. Windows are back-to-back with no gap.
- **Arithmetic:**
  - `high_cnt` is WIN_LOG2+1 bits wide.
  - `d = high_cnt - 2^(WIN_LOG2-1)`, range -2^(WIN_LOG2-1)..+2^(WIN_LOG2-1).
  - `sample = d << (12-WIN_LOG2)`.
  - The single value +2048 saturates to +2047. There is no other clipping.
- **Handshake:**
  - At window end, `sample_out` loads and `sample_valid` is set.
  - A transfer occurs on any cycle with `sample_valid && sample_ready`; `sample_valid` then clears on the next cycle.
  - If a window completes while `sample_valid` is high and no transfer happens that cycle:
    - the new sample overwrites `sample_out`;
    - `sample_valid` stays 1;
    - `overrun` pulses.
  - If a transfer and a new window completion coincide, the new sample loads, `sample_valid` stays 1, and there is no overrun.
- **`active`:** updates at each window end. It is 1 if any edge (rise or fall) of `pin_s` was seen during that window.
- **Reset values:** `sample_out` = 0, `sample_valid` = 0, `overrun` = 0, `active` = 0, FSM = IDLE, counters = 0, synchronizer flops = 0.
- **Reset mid-window:** discards the partial window. The first sample after reset release reflects only a full window.

## Timing
- Pin to `pin_s`: `SYNC_STAGES` cycles (plus 2 more with `PMOD_PWM_RX_DEGLITCH_EN`).
- Window end to `sample_valid`/`sample_out` update: 1 cycle (registered).
- Sample period: exactly 2^WIN_LOG2 cycles once in COUNT.
- `overrun` is registered and asserts in the same cycle as the overwriting `sample_out` update.
- `sample_ready` may be held high permanently. `sample_valid` is then high for exactly 1 cycle per window.

## Configuration
- `PMOD_PWM_RX_DEGLITCH_EN` defined:
  - a 3-tap majority filter follows the synchronizer;
  - `pin_s` changes only when 2 of the last 3 synchronized samples agree;
  - single-cycle glitches are rejected.
- `PMOD_PWM_RX_DEGLITCH_EN` undefined: `pin_s` is the raw synchronizer output and there is no extra latency.

## Structure
- Package `pmod_pwm_pkg` holds:
  - `SAMPLE_W = 12`;
  - `SAMPLE_MAX = 12'sh7FF`, `SAMPLE_MIN = 12'sh800`;
  - the FSM state enum (IDLE, COUNT).
- Sub-module `pmod_pwm_rx_sync` contains the synchronizer chain, the optional deglitch filter and the edge detectors. It outputs `pin_s`, `rise` and `any_edge`.
- The top level holds the FSM, counters, arithmetic and output register.

## Test plan
All scenarios use WIN_LOG2 = 8.
- **Constant low/high:** hold `pwm_in` = 0 through the idle timeout, with `sample_ready` = 1 → samples of -2048 every 256 cycles, `active` = 0. Hold `pwm_in` = 1 → +2047 (saturated).
- **Duty cycle:** square wave with period 16 → 50% duty gives 0; 25% duty gives -1024; 75% duty gives +1024. `active` = 1 in every case.
- **Backpressure:** `sample_ready` = 0 for 3 windows at 25% duty → `overrun` pulses twice, `sample_out` = -1024, and `sample_valid` is held. Raise `sample_ready` → one transfer, then `sample_valid` = 0 until the next window.
- **Coincident accept:** `sample_ready` rises exactly on a window-completion cycle → no `overrun`, the new sample loads, `sample_valid` stays 1.
- **Reset mid-window:** assert `rst` at `win_cnt` = 100 → all outputs 0 immediately and FSM in IDLE. The first sample after release is based on a complete window only.
- **Deglitch:** with `PMOD_PWM_RX_DEGLITCH_EN`, a 1-cycle high pulse on a low line → output stays -2048. Without the macro → -2048 + 16 = -2032.
